// File: rtl/alu_operand_stage_if.sv
// Handshake and payload bundle between the decode stage, the ALU operand
// stage and the ALU.
//   master : decode/forwarding side driver and ALU-side consumer (testbench)
//   slave  : alu_operand_stage
//   Upstream   : valid_in/ready_out plus decoded fields and forwarding sources
//   Downstream : valid_out/ready_in plus a_out/b_out/f_out/illegal_out
//   Status     : issued_out, count of completed output transfers
interface alu_operand_stage_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
);
   logic             valid_in;
   logic             ready_out;
   logic [1:0]       alu_op_in;
   logic [5:0]       funct_in;
   logic [4:0]       rs_addr_in;
   logic [4:0]       rt_addr_in;
   logic [WIDTH-1:0] rs_data_in;
   logic [WIDTH-1:0] rt_data_in;
   logic [15:0]      imm_in;
   logic             alu_src_in;
   logic             exmem_we_in;
   logic             memwb_we_in;
   logic [4:0]       exmem_addr_in;
   logic [4:0]       memwb_addr_in;
   logic [WIDTH-1:0] exmem_data_in;
   logic [WIDTH-1:0] memwb_data_in;
   logic             flush_in;
   logic             ready_in;
   logic             valid_out;
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic [2:0]       f_out;
   logic             illegal_out;
   logic [CNT_W-1:0] issued_out;

   modport master (
      output valid_in, alu_op_in, funct_in, rs_addr_in, rt_addr_in,
             rs_data_in, rt_data_in, imm_in, alu_src_in,
             exmem_we_in, memwb_we_in, exmem_addr_in, memwb_addr_in,
             exmem_data_in, memwb_data_in, flush_in, ready_in,
      input  ready_out, valid_out, a_out, b_out, f_out, illegal_out,
             issued_out
   );

   modport slave (
      input  valid_in, alu_op_in, funct_in, rs_addr_in, rt_addr_in,
             rs_data_in, rt_data_in, imm_in, alu_src_in,
             exmem_we_in, memwb_we_in, exmem_addr_in, memwb_addr_in,
             exmem_data_in, memwb_data_in, flush_in, ready_in,
      output ready_out, valid_out, a_out, b_out, f_out, illegal_out,
             issued_out
   );
endinterface

// File: rtl/alu_operand_stage.sv
// Execute-stage issue register ahead of the ALU. Decodes the 3-bit ALU
// function from ALUOp/funct, resolves rs/rt through EX/MEM then MEM/WB
// forwarding, applies the sign-extended immediate mux and holds the result
// behind a valid/ready handshake.
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : alu_operand_stage_if.slave (upstream fields, forwarding
//              sources, downstream operands, issued-operation counter)
module alu_operand_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input logic                clk_in,
   input logic                rst_n_in,
   alu_operand_stage_if.slave bus
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   localparam int unsigned IMM_W = 16;

   logic [0:0]       state_q;
   logic [0:0]       state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       f_q;
   logic             illegal_q;
   logic [CNT_W-1:0] issued_q;

   logic             ready_c;
   logic             capture_c;
   logic             xfer_c;
   logic [2:0]       f_c;
   logic             illegal_c;
   logic [WIDTH-1:0] a_fwd_c;
   logic [WIDTH-1:0] rt_fwd_c;
   logic [WIDTH-1:0] b_sel_c;

   // Handshake qualifiers; flush only blocks the capture, never ready.
   assign ready_c   = (state_q == EMPTY) || bus.ready_in;
   assign capture_c = bus.valid_in && ready_c && !bus.flush_in;
   assign xfer_c    = (state_q == FULL) && bus.ready_in;

   // ALU function decode.
   always_comb begin
      f_c       = 3'b010;
      illegal_c = 1'b0;
      case (bus.alu_op_in)
         2'b00: f_c = 3'b010;
         2'b01: f_c = 3'b110;
         2'b11: f_c = 3'b001;
         default: begin
            case (bus.funct_in)
               6'b100000: f_c = 3'b010;
               6'b100010: f_c = 3'b110;
               6'b100100: f_c = 3'b000;
               6'b100101: f_c = 3'b001;
               6'b101010: f_c = 3'b111;
               default:   illegal_c = 1'b1;
            endcase
         end
      endcase
   end

   // Operand forwarding: EX/MEM wins over MEM/WB, register 0 never forwards.
   always_comb begin
      a_fwd_c = bus.rs_data_in;
      if (bus.exmem_we_in && (bus.exmem_addr_in == bus.rs_addr_in) &&
          (bus.rs_addr_in != 5'd0)) begin
         a_fwd_c = bus.exmem_data_in;
      end else if (bus.memwb_we_in && (bus.memwb_addr_in == bus.rs_addr_in) &&
                   (bus.rs_addr_in != 5'd0)) begin
         a_fwd_c = bus.memwb_data_in;
      end

      rt_fwd_c = bus.rt_data_in;
      if (bus.exmem_we_in && (bus.exmem_addr_in == bus.rt_addr_in) &&
          (bus.rt_addr_in != 5'd0)) begin
         rt_fwd_c = bus.exmem_data_in;
      end else if (bus.memwb_we_in && (bus.memwb_addr_in == bus.rt_addr_in) &&
                   (bus.rt_addr_in != 5'd0)) begin
         rt_fwd_c = bus.memwb_data_in;
      end

      b_sel_c = bus.alu_src_in
              ? {{(WIDTH-IMM_W){bus.imm_in[IMM_W-1]}}, bus.imm_in}
              : rt_fwd_c;
   end

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= EMPTY;
      else           state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (capture_c) state_d = FULL;
         end
         default: begin
            if (bus.flush_in)            state_d = EMPTY;
            else if (xfer_c && !capture_c) state_d = EMPTY;
         end
      endcase
   end

   // Operand registers load only on capture; flush leaves them stale.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         a_q       <= '0;
         b_q       <= '0;
         f_q       <= 3'b000;
         illegal_q <= 1'b0;
      end else if (capture_c) begin
         a_q       <= a_fwd_c;
         b_q       <= b_sel_c;
         f_q       <= f_c;
         illegal_q <= illegal_c;
      end
   end

   // Saturating count of output transfers, flush does not suppress it.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         issued_q <= '0;
      end else if (xfer_c && (issued_q != {CNT_W{1'b1}})) begin
         issued_q <= issued_q + CNT_W'(1);
      end
   end

   assign bus.ready_out   = ready_c;
   assign bus.valid_out   = (state_q == FULL);
   assign bus.a_out       = a_q;
   assign bus.b_out       = b_q;
   assign bus.f_out       = f_q;
   assign bus.illegal_out = illegal_q;
   assign bus.issued_out  = issued_q;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Execute-stage issue register that sits directly upstream of the ALU. It takes decoded instruction fields from the decode stage and generates the 3-bit ALU function code from ALUOp/funct. It resolves both source operands through EX/MEM and MEM/WB forwarding, applies the immediate mux, and registers the result behind a valid/ready handshake. Registered a_out/b_out/f_out drive the ALU's a_in/b_in/f_in directly.

## Interface
- WIDTH, 32, datapath width
- CNT_W, 16, width of the issued-operation counter

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- valid_in  input  1  upstream has an operation
- ready_out  output  1  stage can accept this cycle
- alu_op_in  input  2  00 add, 01 sub, 10 R-type (use funct), 11 or
- funct_in  input  6  R-type funct field
- rs_addr_in, rt_addr_in  input  5  source register numbers
- rs_data_in, rt_data_in  input  WIDTH  register-file read data
- imm_in  input  16  immediate field
- alu_src_in  input  1  1: b operand = sign-extended imm_in
- exmem_we_in, memwb_we_in  input  1  forwarding source write enables
- exmem_addr_in, memwb_addr_in  input  5  forwarding destination registers
- exmem_data_in, memwb_data_in  input  WIDTH  forwarding data
- flush_in  input  1  kill held and incoming operation
- ready_in  input  1  downstream accepts
- valid_out  output  1  a_out/b_out/f_out hold a live operation
- a_out, b_out  output  WIDTH  ALU operands
- f_out  output  3  ALU function
- illegal_out  output  1  registered: funct not recognised
- issued_out  output  CNT_W  count of completed output transfers

## Operation
- Function map: alu_op 00 -> 010; 01 -> 110; 11 -> 001; 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Any other funct -> 010 with illegal_out=1 for that operation.
- Forwarding per source, evaluated at capture: if exmem_we_in and exmem_addr_in==addr and addr!=0 -> exmem_data_in. Otherwise, if the same test passes on memwb -> memwb_data_in. Otherwise -> register-file data. EX/MEM has priority when both match. Register 0 is never forwarded.
- a_out = forwarded rs. b_out = alu_src_in ? {{16{imm_in[15]}},imm_in} : forwarded rt. rt forwarding is ignored when alu_src_in=1.
- ready_out = !valid_out || ready_in (combinational, independent of flush_in).
- Capture when valid_in && ready_out && !flush_in. Then a_out/b_out/f_out/illegal_out load and valid_out=1.
- Output transfer when valid_out && ready_in. With no new capture in the same cycle, valid_out goes to 0.
- flush_in=1: valid_out=0 next cycle. An incoming operation that cycle is dropped, although ready_out may be 1. A held operation is discarded and not counted. Data registers keep their stale values.
- issued_out increments on each output transfer, including when flush_in is asserted in the same cycle as a transfer. It saturates at all-ones.
- State: EMPTY (valid_out=0) and FULL (valid_out=1). EMPTY->FULL on capture. FULL->FULL on stall, or on transfer with simultaneous capture. FULL->EMPTY on transfer without capture, or on flush.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): valid_out=0, a_out=0, b_out=0, f_out=000, illegal_out=0, issued_out=0. ready_out=1 during and after reset.
- Latency: 1 cycle, from capture edge to valid_out.
- Throughput: 1 operation/cycle while ready_in=1.
- While valid_out && !ready_in, a_out/b_out/f_out/illegal_out hold stable.
- Forwarding data is sampled only on the capture edge. Later changes to the forwarding inputs do not update a held operation.
- Reset asserted mid-operation: the held operation is lost and the counter clears. No output transfer is counted for that cycle.

## Test plan
- Reset: hold rst_n_in=0 with valid_in=1 and random fields -> valid_out=0, all outputs 0, ready_out=1. Release, then one capture -> valid_out=1 on the next edge.
- Function map: stream all five R-type functs plus alu_op 00/01/11, with ready_in=1 -> f_out sequence 010,110,000,001,111,010,110,001. Then funct 000000 -> f_out=010, illegal_out=1.
- Forwarding: rs=rt=5, exmem (we=1, addr 5, data 0xAAAA0000) and memwb (we=1, addr 5, data 0x5555) -> a_out=b_out=0xAAAA0000. Drop exmem_we -> 0x5555. Repeat with rs=0 -> a_out=rs_data_in.
- Immediate: alu_src_in=1, imm_in=0xFFFE -> b_out=0xFFFFFFFE. imm_in=0x7FFF -> b_out=0x00007FFF.
- Backpressure: issue ops A, B with ready_in=0 for 3 cycles -> A held stable, ready_out=0, B not captured. Raise ready_in -> A transfers, then B, and issued_out=2.
- Flush: with valid_out=1, ready_in=0, assert flush_in and valid_in for one cycle -> valid_out=0 next cycle, the incoming op is dropped, and issued_out is unchanged.
